// File: rtl/ristretto_exe_stage_pkg.sv
// Execute-stage shared types and constants.
// Shift mode encodings and the shift dispatcher state type.
package ristretto_exe_stage_pkg;

  localparam logic [1:0] SHIFT_LEFT   = 2'd0;
  localparam logic [1:0] SHIFT_RIGHT  = 2'd1;
  localparam logic [1:0] SHIFT_ARIGHT = 2'd2;

  typedef enum logic [1:0] {
    SDISP_IDLE,
    SDISP_RUN,
    SDISP_WB
  } sdisp_state_t;

  function automatic logic shift_mode_legal(
    input logic [1:0] mode
  );
    return (mode == SHIFT_LEFT) ||
           (mode == SHIFT_RIGHT) ||
           (mode == SHIFT_ARIGHT);
  endfunction

endpackage

// File: rtl/ristretto_shift_fastpath.sv
// Combinational 0/1-bit shifter for the dispatcher fast path.
// Illegal modes and a zero shift pass the operand through.
module ristretto_shift_fastpath #(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic                 b0_i,
  input  logic [1:0]           mode_i,
  output logic [DataWidth-1:0] result_o
);
  import ristretto_exe_stage_pkg::*;

  always_comb begin
    result_o = a_i;
    if (b0_i) begin
      unique case (1'b1)
        (mode_i == SHIFT_LEFT):
          result_o = {a_i[DataWidth-2:0], 1'b0};
        (mode_i == SHIFT_RIGHT):
          result_o = {1'b0, a_i[DataWidth-1:1]};
        (mode_i == SHIFT_ARIGHT):
          result_o = {a_i[DataWidth-1], a_i[DataWidth-1:1]};
        default:
          result_o = a_i;
      endcase
    end
  end

endmodule

// File: rtl/ristretto_shift_dispatcher.sv
// Shift dispatcher: short shifts finish locally, 2..31-bit shifts
// run the sequential shifter for exactly B enable cycles.
module ristretto_shift_dispatcher #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 shft_valid_i,
  output logic                 shft_ready_o,
  input  logic [DataWidth-1:0] shft_operand_a_i,
  input  logic [4:0]           shft_operand_b_i,
  input  logic [1:0]           shft_mode_i,
  input  logic [4:0]           shft_rd_i,
  output logic [DataWidth-1:0] sshft_operand_a_o,
  output logic [4:0]           sshft_operand_b_o,
  output logic [1:0]           sshft_mode_o,
  output logic                 sshft_en_o,
  input  logic                 sshft_busy_i,
  input  logic [DataWidth-1:0] sshft_result_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [DataWidth-1:0] wb_result_o,
  output logic [4:0]           wb_rd_o
);
  import ristretto_exe_stage_pkg::*;

  sdisp_state_t         state_q, state_d;
  logic [DataWidth-1:0] a_q;
  logic [4:0]           b_q;
  logic [1:0]           mode_q;
  logic [4:0]           rd_q;
  logic [4:0]           cnt_q;
  logic                 fast_q;
  logic [DataWidth-1:0] res_q;
  logic [DataWidth-1:0] fast_res;
  logic                 accept;
  logic                 is_fast;

  ristretto_shift_fastpath #(
    .DataWidth(DataWidth)
  ) u_fastpath (
    .a_i     (shft_operand_a_i),
    .b0_i    (shft_operand_b_i[0]),
    .mode_i  (shft_mode_i),
    .result_o(fast_res)
  );

  assign accept  = shft_valid_i & shft_ready_o & ~flush_i;
  assign is_fast = (shft_operand_b_i[4:1] == 4'd0) |
                   ~shift_mode_legal(shft_mode_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SDISP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SDISP_IDLE:
        if (accept) state_d = is_fast ? SDISP_WB : SDISP_RUN;
      SDISP_RUN:
        if (cnt_q == 5'd1) state_d = SDISP_WB;
      SDISP_WB:
        if (wb_ready_i) state_d = SDISP_IDLE;
      default:
        state_d = SDISP_IDLE;
    endcase
    if (flush_i) state_d = SDISP_IDLE;
  end

  always_comb begin
    shft_ready_o = (state_q == SDISP_IDLE) & ~rst_i;
    // Enable is gated combinationally so a kill stops the shifter at once
    sshft_en_o   = (state_q == SDISP_RUN) & ~flush_i & ~rst_i;
    wb_valid_o   = (state_q == SDISP_WB);
    wb_rd_o      = rd_q;
    wb_result_o  = '0;
    if (wb_valid_o) wb_result_o = fast_q ? res_q : sshft_result_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      fast_q <= 1'b0;
      res_q  <= '0;
    end else if (accept) begin
      a_q    <= shft_operand_a_i;
      b_q    <= shft_operand_b_i;
      mode_q <= shft_mode_i;
      rd_q   <= shft_rd_i;
      cnt_q  <= shft_operand_b_i;
      fast_q <= is_fast;
      res_q  <= fast_res;
    end else if (sshft_en_o) begin
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  assign sshft_operand_a_o = a_q;
  assign sshft_operand_b_o = b_q;
  assign sshft_mode_o      = mode_q;

  // A slow result is only trustworthy once the shifter has gone idle
  a_busy_in_wb: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == SDISP_WB && !fast_q) |-> !sshft_busy_i
  );

endmodule

// File: tb/tb_ristretto_shift_dispatcher.sv
// Bench for ristretto_shift_dispatcher with a behavioural
// one-bit-per-enable shifter standing in for the real one.
module tb_ristretto_shift_dispatcher;
  import ristretto_exe_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        shft_valid_i = 1'b0;
  logic        shft_ready_o;
  logic [31:0] shft_operand_a_i = '0;
  logic [4:0]  shft_operand_b_i = '0;
  logic [1:0]  shft_mode_i = '0;
  logic [4:0]  shft_rd_i = '0;
  logic [31:0] sshft_operand_a_o;
  logic [4:0]  sshft_operand_b_o;
  logic [1:0]  sshft_mode_o;
  logic        sshft_en_o;
  logic        sshft_busy_i;
  logic [31:0] sshft_result_i;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ristretto_shift_dispatcher #(.DataWidth(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .shft_valid_i     (shft_valid_i),
    .shft_ready_o     (shft_ready_o),
    .shft_operand_a_i (shft_operand_a_i),
    .shft_operand_b_i (shft_operand_b_i),
    .shft_mode_i      (shft_mode_i),
    .shft_rd_i        (shft_rd_i),
    .sshft_operand_a_o(sshft_operand_a_o),
    .sshft_operand_b_o(sshft_operand_b_o),
    .sshft_mode_o     (sshft_mode_o),
    .sshft_en_o       (sshft_en_o),
    .sshft_busy_i     (sshft_busy_i),
    .sshft_result_i   (sshft_result_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_rd_o          (wb_rd_o)
  );

  // Stand-in shifter: one bit per enabled cycle, restarts past B
  logic [31:0] acc = '0;
  int          k = 0;

  function automatic logic [31:0] sh1(input logic [31:0] v,
                                      input logic [1:0] m);
    case (m)
      SHIFT_LEFT:   return v << 1;
      SHIFT_RIGHT:  return v >> 1;
      SHIFT_ARIGHT: return {v[31], v[31:1]};
      default:      return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      acc <= '0;
      k   <= 0;
    end else if (sshft_en_o) begin
      acc <= sh1((k == 0) ? sshft_operand_a_o : acc, sshft_mode_o);
      k   <= (k + 1 >= int'(sshft_operand_b_o)) ? 0 : k + 1;
    end else begin
      k <= 0;
    end
  end

  assign sshft_result_i = acc;
  assign sshft_busy_i   = (k != 0);

  function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                            input int b,
                                            input logic [1:0] m);
    case (m)
      SHIFT_LEFT:   return a << b;
      SHIFT_RIGHT:  return a >> b;
      SHIFT_ARIGHT: return 32'($signed(a) >>> b);
      default:      return a;
    endcase
  endfunction

  // Drives one op and measures latency, enable cycles and hold stability
  task automatic run_op(input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] m, input logic [4:0] rd,
                        input int hold,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output int en_n, output int lat, output bit stable);
    bit seen;
    wb_ready_i = (hold == 0);
    @(posedge clk); #1;
    shft_valid_i = 1'b1;
    shft_operand_a_i = a;
    shft_operand_b_i = b;
    shft_mode_i = m;
    shft_rd_i = rd;
    @(posedge clk); #1;
    shft_valid_i = 1'b0;
    en_n = 0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (sshft_en_o) en_n++;
      if (wb_valid_o) seen = 1;
    end
    if (!seen) lat = -1;
    res = wb_result_o;
    rdo = wb_rd_o;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!wb_valid_o || wb_result_o !== res ||
          wb_rd_o !== rdo || shft_ready_o) stable = 0;
    end
    wb_ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    nvec++;
    if (shft_ready_o !== 1'b0) begin
      nerr++; $display("FAIL reset_ready got %b want 0", shft_ready_o);
    end
    nvec++;
    if (wb_valid_o !== 1'b0 || sshft_en_o !== 1'b0) begin
      nerr++; $display("FAIL reset_ctl got valid=%b en=%b want 0 0",
                       wb_valid_o, sshft_en_o);
    end
    nvec++;
    if (wb_result_o !== 32'h0 || wb_rd_o !== 5'h0) begin
      nerr++; $display("FAIL reset_wb got %h/%0d want 0/0",
                       wb_result_o, wb_rd_o);
    end
    nvec++;
    if (sshft_operand_a_o !== 32'h0 || sshft_operand_b_o !== 5'h0 ||
        sshft_mode_o !== 2'h0) begin
      nerr++; $display("FAIL reset_sshft got %h %0d %0d want 0 0 0",
                       sshft_operand_a_o, sshft_operand_b_o, sshft_mode_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (shft_ready_o !== 1'b1) begin
      nerr++; $display("FAIL post_reset_ready got %b want 1", shft_ready_o);
    end
  endtask

  task automatic check_op(input string nm, input logic [31:0] a,
                          input logic [4:0] b, input logic [1:0] m,
                          input logic [4:0] rd, input int hold);
    logic [31:0] res, exp;
    logic [4:0]  rdo;
    int en_n, lat, exp_en, exp_lat;
    bit stable, fast;
    fast = (b < 2) || !(m inside {SHIFT_LEFT, SHIFT_RIGHT, SHIFT_ARIGHT});
    exp = ref_shift(a, int'(b), m);
    exp_en = fast ? 0 : int'(b);
    exp_lat = exp_en + 1;
    run_op(a, b, m, rd, hold, res, rdo, en_n, lat, stable);
    nvec++;
    if (res !== exp) begin
      nerr++; $display("FAIL %s result got %h want %h", nm, res, exp);
    end
    nvec++;
    if (rdo !== rd) begin
      nerr++; $display("FAIL %s rd got %0d want %0d", nm, rdo, rd);
    end
    nvec++;
    if (lat != exp_lat) begin
      nerr++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat);
    end
    nvec++;
    if (en_n != exp_en) begin
      nerr++; $display("FAIL %s en_cycles got %0d want %0d", nm, en_n, exp_en);
    end
    if (hold > 0) begin
      nvec++;
      if (!stable) begin
        nerr++; $display("FAIL %s hold_stable got 0 want 1", nm);
      end
    end
  endtask

  task automatic test_slow;
    check_op("slow_left", 32'h0000_0001, 5'd4, SHIFT_LEFT, 5'd5, 0);
    check_op("slow_aright", 32'h8000_0000, 5'd31, SHIFT_ARIGHT, 5'd3, 0);
    check_op("slow_right2", 32'hF000_000F, 5'd2, SHIFT_RIGHT, 5'd1, 0);
  endtask

  task automatic test_fast;
    check_op("fast_right1", 32'h8000_0003, 5'd1, SHIFT_RIGHT, 5'd2, 0);
    check_op("fast_left0", 32'h1234_5678, 5'd0, SHIFT_LEFT, 5'd4, 0);
    check_op("fast_illegal", 32'hDEAD_BEEF, 5'd7, 2'd3, 5'd6, 0);
    check_op("fast_aright1", 32'h8000_0002, 5'd1, SHIFT_ARIGHT, 5'd8, 0);
  endtask

  task automatic test_backpressure;
    check_op("backpressure", 32'h0000_0003, 5'd2, SHIFT_LEFT, 5'd7, 3);
    @(negedge clk);
    nvec++;
    if (shft_ready_o !== 1'b1) begin
      nerr++; $display("FAIL bp_idle_after got %b want 1", shft_ready_o);
    end
  endtask

  task automatic test_flush;
    int bad;
    @(posedge clk); #1;
    shft_valid_i = 1'b1;
    shft_operand_a_i = 32'h0000_1234;
    shft_operand_b_i = 5'd10;
    shft_mode_i = SHIFT_LEFT;
    shft_rd_i = 5'd11;
    @(posedge clk); #1;
    shft_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (sshft_en_o !== 1'b1) begin
      nerr++; $display("FAIL flush_pre_en got %b want 1", sshft_en_o);
    end
    flush_i = 1'b1;
    #1;
    nvec++;
    if (sshft_en_o !== 1'b0) begin
      nerr++; $display("FAIL flush_en_drop got %b want 0", sshft_en_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wb_valid_o || sshft_en_o) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL flush_quiet got %0d active cycles want 0", bad);
    end
    check_op("after_flush", 32'h0000_00F0, 5'd4, SHIFT_RIGHT, 5'd12, 0);
  endtask

  task automatic test_reset_mid_run;
    @(posedge clk); #1;
    shft_valid_i = 1'b1;
    shft_operand_a_i = 32'hCAFE_F00D;
    shft_operand_b_i = 5'd20;
    shft_mode_i = SHIFT_ARIGHT;
    shft_rd_i = 5'd21;
    @(posedge clk); #1;
    shft_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    nvec++;
    if (shft_ready_o !== 1'b0 || sshft_en_o !== 1'b0) begin
      nerr++; $display("FAIL rst_mid_cycle got ready=%b en=%b want 0 0",
                       shft_ready_o, sshft_en_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (wb_valid_o !== 1'b0 || sshft_en_o !== 1'b0 ||
        wb_result_o !== 32'h0 || wb_rd_o !== 5'h0 ||
        sshft_operand_a_o !== 32'h0 || sshft_operand_b_o !== 5'h0 ||
        sshft_mode_o !== 2'h0 || shft_ready_o !== 1'b1) begin
      nerr++; $display("FAIL rst_mid_outputs got v=%b en=%b r=%h rd=%0d a=%h b=%0d m=%0d rdy=%b want 0 0 0 0 0 0 0 1",
                       wb_valid_o, sshft_en_o, wb_result_o, wb_rd_o,
                       sshft_operand_a_o, sshft_operand_b_o,
                       sshft_mode_o, shft_ready_o);
    end
    check_op("after_reset", 32'h0000_0005, 5'd2, SHIFT_LEFT, 5'd9, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [4:0]  b, rd;
    logic [1:0]  m;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2))
                                       : 5'($urandom_range(0, 31));
      m  = 2'($urandom_range(0, 3));
      rd = 5'($urandom);
      check_op("random", a, b, m, rd, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_slow();
    test_fast();
    test_backpressure();
    test_flush();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
